// File: rtl/rr_packet_merger_pkg.sv
// Shared types and constants for the two-source round-robin packet merger.
package rr_packet_merger_pkg;

  localparam int DEFAULT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick_2.sv
// Two-request priority picker: a lone request wins, a tie goes to the priority holder.
module rr_pick_2 (
  input  logic       req0,
  input  logic       req1,
  input  logic       prio,
  output logic [1:0] pick
);

  always_comb begin
    pick = 2'b00;
    if (req0 && req1) pick = prio ? 2'b10 : 2'b01;
    else              pick = {req1, req0};
  end

endmodule

// File: rtl/rr_packet_merger_2.sv
// Merges two packet streams with per-packet round-robin and one registered output stage.
// state | meaning
// IDLE  | unlocked, next packet start is arbitrated between the sources
// LOCK0 | mid-packet on source 0, only source 0 may send
// LOCK1 | mid-packet on source 1, only source 1 may send
module rr_packet_merger_2
  import rr_packet_merger_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in0_valid,
  output logic         in0_ready,
  input  logic [W-1:0] in0_data,
  input  logic         in0_last,
  input  logic         in1_valid,
  output logic         in1_ready,
  input  logic [W-1:0] in1_data,
  input  logic         in1_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         out_src
);

  state_t         state_q, state_d;
  logic           prio_q, prio_d;
  logic [1:0]     req_q, req_d;
  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   out_data_q, out_data_d;
  logic           out_last_q, out_last_d;
  logic           out_src_q, out_src_d;
  logic [1:0]     pick;
  logic [1:0]     sel;
  logic           accept;
  logic           fire0, fire1, fire, fire_last;

  // Arbitration sees last cycle's valids so the readies never follow in*_valid combinationally.
  rr_pick_2 u_pick (
    .req0 (req_q[0]),
    .req1 (req_q[1]),
    .prio (prio_q),
    .pick (pick)
  );

  assign accept    = !out_valid_q || out_ready;
  assign fire0     = in0_valid && in0_ready;
  assign fire1     = in1_valid && in1_ready;
  assign fire      = fire0 || fire1;
  assign fire_last = fire1 ? in1_last : in0_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (fire) state_d = fire_last ? IDLE : (fire1 ? LOCK1 : LOCK0);
  end

  always_comb begin
    sel = 2'b00;
    case (state_q)
      IDLE:    sel = pick;
      LOCK0:   sel = 2'b01;
      LOCK1:   sel = 2'b10;
      default: sel = 2'b00;
    endcase
    in0_ready = sel[0] && accept;
    in1_ready = sel[1] && accept;
  end

  always_comb begin
    prio_d      = prio_q;
    req_d       = {in1_valid, in0_valid};
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;
    // Priority passes to the other source only at a packet boundary.
    if (fire && fire_last) prio_d = !fire1;
    if (accept) out_valid_d = fire;
    if (fire) begin
      out_data_d = fire1 ? in1_data : in0_data;
      out_last_d = fire_last;
      out_src_d  = fire1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_q      <= 1'b0;
      req_q       <= 2'b00;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= 1'b0;
    end else begin
      prio_q      <= prio_d;
      req_q       <= req_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_src   = out_src_q;

endmodule
